overdrive_stage: RTL
====================

Name: overdrive_stage

Overview:
Parametrised, pipelined waveshaping stage for the synth audio path. It supports bypass, hard-clip compression, gain-plus-clip overdrive and half-wave overdrive on signed streaming samples. Configuration changes are double-buffered and committed at a zero crossing, or after a timeout, to avoid clicks. It sits between the oscillator/mixer output and the volume/DAC stage, and keeps a saturating clip-event counter for UI metering.

Parameters:
DATA_W, 32, sample width (signed two's complement)
GAIN_W, 8, gain width; unsigned fixed point with 4 fractional bits (0x10 = 1.0)
CNT_W, 16, clip counter width
TIMEOUT, 256, valid input samples in PENDING before forced commit (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  input sample strobe
in_sample  in  DATA_W  signed input sample
cfg_load  in  1  one-cycle strobe; capture cfg_* into shadow registers
cfg_mode  in  2  0 bypass, 1 compress, 2 overdrive, 3 half-wave overdrive
cfg_pos_thr  in  DATA_W-1  unsigned positive clip level
cfg_neg_thr  in  DATA_W-1  unsigned magnitude of negative clip level
cfg_gain  in  GAIN_W  overdrive gain, 4 fractional bits
clr_count  in  1  clear clip_count
out_valid  out  1  output sample strobe
out_sample  out  DATA_W  signed shaped sample
clip_active  out  1  current out_sample was clipped
cfg_pending  out  1  shadow configuration awaiting commit
clip_count  out  CNT_W  saturating count of clipped samples

Behaviour:
- Reset values:
  - out_valid=0, out_sample=0, clip_active=0, cfg_pending=0, clip_count=0.
  - Active and shadow config: mode=0, pos_thr=neg_thr=all ones, gain=0x10.
  - Pipeline valids cleared, FSM in IDLE, timeout counter 0, last-sign register 0 (positive).
- Reset mid-stream discards all in-flight samples; out_valid is 0 on the cycle after reset is asserted.
- Streaming only, no backpressure. Fixed latency of 3 cycles: in_valid at cycle N gives out_valid at N+3. Bubbles propagate unchanged.
- Stage 1: register sample and the active config used for it. In modes 2 and 3, form the signed product sample × {0,gain} (DATA_W+GAIN_W+1 bits). In modes 0 and 1, the product is the sample itself.
- Stage 2: arithmetic shift right by 4 (modes 2 and 3 only), then saturate to DATA_W. Values above 2^(DATA_W-1)-1 become the max; values below -2^(DATA_W-1) become the min.
- Stage 3, clipping:
  - Mode 0: pass through, clip_active=0.
  - Modes 1 and 2: x > pos_thr → pos_thr; x < -neg_thr → -neg_thr; otherwise x. clip_active=1 when either limit applied.
  - Mode 3: as mode 2, except any x < 0 → 0, with clip_active=1.
  - Gain saturation alone, without a threshold hit, does not set clip_active.
- clip_count:
  - Increments by 1 on each out_valid with clip_active=1; saturates at all ones.
  - clr_count sets it to 0 and wins over a simultaneous increment.
- Config FSM:
  - IDLE: cfg_load captures the cfg_* inputs into shadow and moves to PENDING. Timeout counter is cleared.
  - PENDING: cfg_pending=1. On each in_valid, test for a crossing: sign(in_sample) differs from last-sign, or in_sample==0.
  - On a crossing, or when the timeout counter reaches TIMEOUT-1, copy shadow to active and return to IDLE. Otherwise increment the timeout counter.
  - The sample that triggers the commit is processed with the new config.
  - cfg_load while PENDING overwrites shadow and restarts the timeout. It also takes priority over a same-cycle crossing or timeout, so no commit happens that cycle.
- last-sign updates on every in_valid, in all states.
- Thresholds of 0 are legal: a nonzero sample clips to 0.

Test Plan:
(DATA_W=16, GAIN_W=8, TIMEOUT=8)
1. Reset, then bypass with in_sample=1234 at cycle 0 → out_sample=1234 with out_valid at cycle 3; clip_count=0, clip_active=0.
2. Commit mode 1, pos 1000, neg 500; feed 2000, -2000, 300 → outputs 1000, -500, 300; clip_active 1,1,0; clip_count=2.
3. Commit mode 2, gain 0x30, both thresholds 30000; feed 12000, -5000, 2000 → 30000 (36000 saturates to 32767, then clips), -15000, 6000; clip_count +1.
4. Mode 3, gain 0x20, thresholds max; feed -700, 400 → 0 (clip_active=1), 800 (clip_active=0).
5. cfg_load during positive samples 100…900 with no crossing → cfg_pending high until the 8th valid sample, which uses the new config. Repeat with input 100, -50 → -50 commits immediately. cfg_load together with a crossing → no commit.
6. Reset asserted with 3 samples in flight → out_valid=0 next cycle, no stale samples emerge. clip_count at all ones stays saturated. clr_count together with a clip event → 0.

Source files
------------

// File: rtl/overdrive_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : overdrive_stage_if
// Description : Sample stream, configuration and metering bundle for the
//               overdrive waveshaping stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface overdrive_stage_if #(
   parameter int DATA_W = 32,
   parameter int GAIN_W = 8,
   parameter int CNT_W  = 16
);
   logic                     in_valid;
   logic signed [DATA_W-1:0] in_sample;
   logic                     cfg_load;
   logic [1:0]               cfg_mode;
   logic [DATA_W-2:0]        cfg_pos_thr;
   logic [DATA_W-2:0]        cfg_neg_thr;
   logic [GAIN_W-1:0]        cfg_gain;
   logic                     clr_count;
   logic                     out_valid;
   logic signed [DATA_W-1:0] out_sample;
   logic                     clip_active;
   logic                     cfg_pending;
   logic [CNT_W-1:0]         clip_count;

   // Upstream side: sample source and control/UI agent
   modport master (
      output in_valid, in_sample, cfg_load, cfg_mode, cfg_pos_thr,
             cfg_neg_thr, cfg_gain, clr_count,
      input  out_valid, out_sample, clip_active, cfg_pending, clip_count
   );

   // Waveshaper side
   modport slave (
      input  in_valid, in_sample, cfg_load, cfg_mode, cfg_pos_thr,
             cfg_neg_thr, cfg_gain, clr_count,
      output out_valid, out_sample, clip_active, cfg_pending, clip_count
   );
endinterface
`default_nettype wire

// File: rtl/overdrive_stage.sv
`default_nettype none
// ============================================================================
// Module      : overdrive_stage
// Description : 3-cycle pipelined waveshaper (bypass / compress / overdrive /
//               half-wave overdrive) with zero-crossing config commit and a
//               saturating clip-event counter.
// Revision    : 1.0 - initial release
// ============================================================================
module overdrive_stage #(
   parameter int DATA_W  = 32,
   parameter int GAIN_W  = 8,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 256
) (
   input  logic                clk,
   input  logic                reset,
   overdrive_stage_if.slave    bus
);
   localparam int PW = DATA_W + GAIN_W + 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] c_tmax = TW'(TIMEOUT - 1);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PENDING = 1'b1} state_t;

   state_t                   r_state, w_state_nxt;
   logic [TW-1:0]            r_tcnt, w_tcnt_nxt;
   logic                     r_last_sign;
   logic                     w_commit, w_cross;

   // Active and shadow configuration
   logic [1:0]               r_act_mode, r_shd_mode;
   logic [DATA_W-2:0]        r_act_pos, r_shd_pos, r_act_neg, r_shd_neg;
   logic [GAIN_W-1:0]        r_act_gain, r_shd_gain;

   // Config seen by the sample entering stage 1 (new config on commit)
   logic [1:0]               w_mode;
   logic [DATA_W-2:0]        w_pos, w_neg;
   logic [GAIN_W-1:0]        w_gain;
   logic signed [PW-1:0]     w_prod_a, w_prod_b, w_prod;

   // Pipeline registers
   logic                     r1_valid, r2_valid, r3_valid;
   logic signed [PW-1:0]     r1_prod;
   logic [1:0]               r1_mode, r2_mode;
   logic [DATA_W-2:0]        r1_pos, r1_neg, r2_pos, r2_neg;
   logic signed [DATA_W-1:0] r2_x, r3_sample;
   logic                     r3_clip;
   logic [CNT_W-1:0]         r_cnt;

   logic signed [PW-1:0]     w_shift, w_max, w_min;
   logic signed [DATA_W-1:0] w_sat, w_pos_lim, w_neg_lim, w_clip_val;
   logic                     w_clip;

   assign w_cross = (bus.in_sample[DATA_W-1] != r_last_sign) || (bus.in_sample == '0);

   // Config FSM state, timeout counter and last-sign tracking
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_tcnt      <= '0;
         r_last_sign <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tcnt  <= w_tcnt_nxt;
         if (bus.in_valid) r_last_sign <= bus.in_sample[DATA_W-1];
      end
   end

   // Next state: cfg_load beats any same-cycle crossing or timeout
   always_comb begin
      w_state_nxt = r_state;
      w_tcnt_nxt  = r_tcnt;
      w_commit    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.cfg_load) begin
               w_state_nxt = ST_PENDING;
               w_tcnt_nxt  = '0;
            end
         end
         ST_PENDING: begin
            if (bus.cfg_load) begin
               w_tcnt_nxt = '0;
            end else if (bus.in_valid) begin
               if (w_cross || (r_tcnt == c_tmax)) begin
                  w_commit    = 1'b1;
                  w_state_nxt = ST_IDLE;
                  w_tcnt_nxt  = '0;
               end else begin
                  w_tcnt_nxt = r_tcnt + TW'(1);
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Shadow capture on load, shadow-to-active copy on commit
   always_ff @(posedge clk) begin
      if (reset) begin
         r_shd_mode <= 2'd0;   r_act_mode <= 2'd0;
         r_shd_pos  <= '1;     r_act_pos  <= '1;
         r_shd_neg  <= '1;     r_act_neg  <= '1;
         r_shd_gain <= GAIN_W'(16);
         r_act_gain <= GAIN_W'(16);
      end else begin
         if (bus.cfg_load) begin
            r_shd_mode <= bus.cfg_mode;
            r_shd_pos  <= bus.cfg_pos_thr;
            r_shd_neg  <= bus.cfg_neg_thr;
            r_shd_gain <= bus.cfg_gain;
         end
         if (w_commit) begin
            r_act_mode <= r_shd_mode;
            r_act_pos  <= r_shd_pos;
            r_act_neg  <= r_shd_neg;
            r_act_gain <= r_shd_gain;
         end
      end
   end

   assign w_mode   = w_commit ? r_shd_mode : r_act_mode;
   assign w_pos    = w_commit ? r_shd_pos  : r_act_pos;
   assign w_neg    = w_commit ? r_shd_neg  : r_act_neg;
   assign w_gain   = w_commit ? r_shd_gain : r_act_gain;
   assign w_prod_a = PW'(bus.in_sample);
   assign w_prod_b = PW'($signed({1'b0, w_gain}));
   assign w_prod   = w_mode[1] ? (w_prod_a * w_prod_b) : w_prod_a;

   // Stage 2 datapath: undo gain fraction, saturate to sample width
   assign w_shift = r1_mode[1] ? (r1_prod >>> 4) : r1_prod;
   assign w_max   = PW'({1'b0, {(DATA_W-1){1'b1}}});
   assign w_min   = ~w_max;
   assign w_sat   = (w_shift > w_max) ? {1'b0, {(DATA_W-1){1'b1}}} :
                    (w_shift < w_min) ? {1'b1, {(DATA_W-1){1'b0}}} :
                    w_shift[DATA_W-1:0];

   // Stage 3 datapath: threshold clipping
   assign w_pos_lim = $signed({1'b0, r2_pos});
   assign w_neg_lim = -$signed({1'b0, r2_neg});

   // Clip decision; half-wave mode folds every negative sample to zero
   always_comb begin
      w_clip_val = r2_x;
      w_clip     = 1'b0;
      if (r2_mode != 2'd0) begin
         if (r2_x > w_pos_lim) begin
            w_clip_val = w_pos_lim;
            w_clip     = 1'b1;
         end else if ((r2_mode == 2'd3) && r2_x[DATA_W-1]) begin
            w_clip_val = '0;
            w_clip     = 1'b1;
         end else if (r2_x < w_neg_lim) begin
            w_clip_val = w_neg_lim;
            w_clip     = 1'b1;
         end
      end
   end

   // Three pipeline stages; bubbles ride along as cleared valids
   always_ff @(posedge clk) begin
      if (reset) begin
         r1_valid <= 1'b0; r2_valid <= 1'b0; r3_valid <= 1'b0;
         r1_prod  <= '0;   r1_mode  <= 2'd0; r1_pos <= '1; r1_neg <= '1;
         r2_x     <= '0;   r2_mode  <= 2'd0; r2_pos <= '1; r2_neg <= '1;
         r3_sample <= '0;  r3_clip  <= 1'b0;
      end else begin
         r1_valid <= bus.in_valid;
         r1_prod  <= w_prod;
         r1_mode  <= w_mode;
         r1_pos   <= w_pos;
         r1_neg   <= w_neg;
         r2_valid <= r1_valid;
         r2_x     <= w_sat;
         r2_mode  <= r1_mode;
         r2_pos   <= r1_pos;
         r2_neg   <= r1_neg;
         r3_valid <= r2_valid;
         r3_clip  <= r2_valid & w_clip;
         if (r2_valid) r3_sample <= w_clip_val;
      end
   end

   // Saturating clip-event counter; clear beats increment
   always_ff @(posedge clk) begin
      if (reset || bus.clr_count) begin
         r_cnt <= '0;
      end else if (r2_valid && w_clip && (r_cnt != '1)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign bus.out_valid   = r3_valid;
   assign bus.out_sample  = r3_sample;
   assign bus.clip_active = r3_clip;
   assign bus.cfg_pending = (r_state == ST_PENDING);
   assign bus.clip_count  = r_cnt;
endmodule
`default_nettype wire
